// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles every non-clock, non-reset signal of the fetch sequencer.
//   master : the sequencer (drives memory read, PC strobes, execute offer, status)
//   slave  : the surroundings (PC, program memory, execute unit, start control)
// Signals
//   start                      level request to leave IDLE
//   pc / mem_rd / mem_addr / mem_data     PC value and program-memory read port
//   pc_incr / pc_preload / pc_jsr / pc_ret / pc_addr / pc_rel   PC control strobes
//   exec_valid / exec_op / exec_ready     execute-unit handshake
//   in_sub / halted / error / instr_count status
interface fetch_sequencer_if #(
    parameter int IW    = 16,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic [10:0]      pc;
    logic             mem_rd;
    logic [10:0]      mem_addr;
    logic [IW-1:0]    mem_data;
    logic             pc_incr;
    logic             pc_preload;
    logic             pc_jsr;
    logic             pc_ret;
    logic [10:0]      pc_addr;
    logic [9:0]       pc_rel;
    logic             exec_valid;
    logic [IW-1:0]    exec_op;
    logic             exec_ready;
    logic             in_sub;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, pc, mem_data, exec_ready,
        output mem_rd, mem_addr, pc_incr, pc_preload, pc_jsr, pc_ret,
               pc_addr, pc_rel, exec_valid, exec_op, in_sub, halted,
               error, instr_count
    );

    modport slave (
        output start, pc, mem_data, exec_ready,
        input  mem_rd, mem_addr, pc_incr, pc_preload, pc_jsr, pc_ret,
               pc_addr, pc_rel, exec_valid, exec_op, in_sub, halted,
               error, instr_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetches the instruction at the current pc, decodes it and drives the PC
//   control strobes. Non-flow opcodes are handed to the execute unit over a
//   valid/ready handshake. Tracks the single subroutine level the PC supports
//   and traps a nested JSR or an unmatched RET.
// Ports
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_sequencer_if.master (memory, PC strobes, execute, status)
// Parameters
//   MEM_LAT  program-memory read latency, 1..4 cycles
//   IW       instruction width (opcode lives in bits 15:12, so IW >= 16)
//   CNT_W    retired-instruction counter width
module fetch_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int IW      = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC,
        S_SETUP, S_PULSE, S_HOLD, S_HALTED, S_ERROR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JSR  = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'h4;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t           state_reg;
    logic [1:0]       wait_cnt_reg;
    logic [IW-1:0]    instr_reg;
    logic             mem_rd_reg;
    logic [10:0]      mem_addr_reg;
    logic             pc_incr_reg;
    logic             preload_reg;
    logic             jsr_reg;
    logic             ret_reg;
    logic             exec_valid_reg;
    logic             in_sub_reg;
    logic             halted_reg;
    logic             error_reg;
    logic [CNT_W-1:0] count_reg;

    logic [3:0] opcode;
    assign opcode = instr_reg[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            instr_reg      <= '0;
            mem_rd_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            pc_incr_reg    <= 1'b0;
            preload_reg    <= 1'b0;
            jsr_reg        <= 1'b0;
            ret_reg        <= 1'b0;
            exec_valid_reg <= 1'b0;
            in_sub_reg     <= 1'b0;
            halted_reg     <= 1'b0;
            error_reg      <= 1'b0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        state_reg    <= S_FETCH;
                        mem_rd_reg   <= 1'b1;
                        mem_addr_reg <= bus.pc;
                    end
                end
                S_FETCH: begin
                    mem_rd_reg   <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    // The word is sampled on the MEM_LAT-th edge after the read strobe.
                    if (wait_cnt_reg == LAT_LAST) begin
                        instr_reg <= bus.mem_data;
                        state_reg <= S_DECODE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 2'd1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP: state_reg <= S_SETUP;
                        OP_JMP: begin
                            preload_reg <= 1'b1;
                            state_reg   <= S_SETUP;
                        end
                        OP_JSR: begin
                            if (in_sub_reg) begin
                                error_reg <= 1'b1;
                                state_reg <= S_ERROR;
                            end else begin
                                jsr_reg   <= 1'b1;
                                state_reg <= S_SETUP;
                            end
                        end
                        OP_RET: begin
                            if (!in_sub_reg) begin
                                error_reg <= 1'b1;
                                state_reg <= S_ERROR;
                            end else begin
                                ret_reg   <= 1'b1;
                                state_reg <= S_SETUP;
                            end
                        end
                        OP_HALT: begin
                            // HALT retires here; it never steps the PC.
                            halted_reg <= 1'b1;
                            count_reg  <= count_reg + 1'b1;
                            state_reg  <= S_HALTED;
                        end
                        default: begin
                            exec_valid_reg <= 1'b1;
                            state_reg      <= S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (bus.exec_ready) begin
                        exec_valid_reg <= 1'b0;
                        state_reg      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    pc_incr_reg <= 1'b1;
                    state_reg   <= S_PULSE;
                end
                S_PULSE: begin
                    pc_incr_reg <= 1'b0;
                    state_reg   <= S_HOLD;
                end
                S_HOLD: begin
                    // Selects drop and the next fetch starts on the same edge;
                    // the PC has already settled after the pc_incr rising edge.
                    if (jsr_reg) begin
                        in_sub_reg <= 1'b1;
                    end else if (ret_reg) begin
                        in_sub_reg <= 1'b0;
                    end
                    preload_reg  <= 1'b0;
                    jsr_reg      <= 1'b0;
                    ret_reg      <= 1'b0;
                    count_reg    <= count_reg + 1'b1;
                    mem_rd_reg   <= 1'b1;
                    mem_addr_reg <= bus.pc;
                    state_reg    <= S_FETCH;
                end
                S_HALTED: state_reg <= S_HALTED;
                S_ERROR:  state_reg <= S_ERROR;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_rd      = mem_rd_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.pc_incr     = pc_incr_reg;
    assign bus.pc_preload  = preload_reg;
    assign bus.pc_jsr      = jsr_reg;
    assign bus.pc_ret      = ret_reg;
    assign bus.pc_addr     = instr_reg[10:0];
    assign bus.pc_rel      = instr_reg[9:0];
    assign bus.exec_valid  = exec_valid_reg;
    assign bus.exec_op     = instr_reg;
    assign bus.in_sub      = in_sub_reg;
    assign bus.halted      = halted_reg;
    assign bus.error       = error_reg;
    assign bus.instr_count = count_reg;
endmodule
